// File: rtl/mdc_pkg.sv
// Shared constants and helpers for the multi-digit counter/display.
// Latency: none (pure constants and functions).
// Backpressure: not applicable.
package mdc_pkg;

    // Active-low glyphs, bit 7..0 = A,B,C,D,E,F,G,DP; DP bit left off (1).
    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_A     = 8'b0001_0001;
    localparam logic [7:0] SEG_B     = 8'b1100_0001;
    localparam logic [7:0] SEG_C     = 8'b0110_0011;
    localparam logic [7:0] SEG_D     = 8'b1000_0101;
    localparam logic [7:0] SEG_E     = 8'b0110_0001;
    localparam logic [7:0] SEG_F     = 8'b0111_0001;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    // Nibble to active-low segment pattern, decimal point off.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

    // Largest value a single digit may hold in the chosen radix.
    function automatic logic [3:0] max_digit(input logic bcd);
        return bcd ? 4'd9 : 4'd15;
    endfunction

endpackage

// File: rtl/multi_digit_counter_tick_gen.sv
// Free-running prescaler: Tick is high for one cycle when the count reaches DIV-1.
// Latency: first Tick on cycle DIV-1 after reset, then every DIV cycles.
// Backpressure: none; runs unconditionally.
module tick_gen
    import mdc_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic Clk,
    input  logic Reset,
    output logic Tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap the prescaler from DIV-1 back to zero.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/multi_digit_counter.sv
// N-digit hex/BCD up/down counter with multiplexed common-anode 7-segment driver.
// Latency: Load/tick -> Count_out 1 Clk; count/scan change -> SSeg/Anode 1 Clk.
// Backpressure: none; Load beats a coincident tick. Optional MDC_LEADING_ZERO_BLANK_EN.
module multi_digit_counter
    import mdc_pkg::*;
#(
    parameter int OLD_HZ  = 50_000_000,
    parameter int NEW_HZ  = 2,
    parameter int SCAN_HZ = 1_000,
    parameter int DIGITS  = 4,
    parameter int BCD     = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Load,
    input  logic                  Count_en,
    input  logic                  Up,
    input  logic [DIGITS-1:0]     DP,
    input  logic [4*DIGITS-1:0]   Count_in,
    output logic [4*DIGITS-1:0]   Count_out,
    output logic                  Carry,
    output logic [7:0]            SSeg,
    output logic [DIGITS-1:0]     Anode,
    output logic                  Tick
);

    localparam int         DIV  = OLD_HZ / NEW_HZ;
    localparam int         SDIV = OLD_HZ / SCAN_HZ;
    localparam int         IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] MAXD = max_digit(BCD != 0);

    logic                 tick_cnt;
    logic                 scan_step;

    logic [4*DIGITS-1:0]  count_q, count_d;
    logic                 carry_q, carry_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    anode_q, anode_d;

    logic [3:0]           nib;
    logic                 rip;
    logic [3:0]           cur_digit;
    logic                 cur_dp;
    logic [7:0]           glyph;

    tick_gen #(.DIV(DIV)) u_count_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .Tick  (tick_cnt)
    );

    tick_gen #(.DIV(SDIV)) u_scan_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .Tick  (scan_step)
    );

    // Next count: load (BCD-sanitised) or digit-serial ripple increment/decrement.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        nib     = '0;
        rip     = 1'b0;
        if (Load) begin
            for (int k = 0; k < DIGITS; k++) begin
                nib = Count_in[4*k +: 4];
                if ((BCD != 0) && (nib > 4'd9)) begin
                    nib = 4'd0;
                end
                count_d[4*k +: 4] = nib;
            end
        end else if (Count_en && tick_cnt) begin
            rip = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                nib = count_q[4*k +: 4];
                if (rip) begin
                    if (Up) begin
                        if (nib == MAXD) begin
                            count_d[4*k +: 4] = 4'd0;
                        end else begin
                            count_d[4*k +: 4] = nib + 4'd1;
                            rip = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            count_d[4*k +: 4] = MAXD;
                        end else begin
                            count_d[4*k +: 4] = nib - 4'd1;
                            rip = 1'b0;
                        end
                    end
                end
            end
            // A ripple that escapes the top digit means every digit wrapped.
            carry_d = rip;
        end
    end

    // Advance the scanned digit on each scan step, wrapping after the top digit.
    always_comb begin
        idx_d = idx_q;
        if (scan_step) begin
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

`ifdef MDC_LEADING_ZERO_BLANK_EN
    logic zero_above;
    logic blank;
`endif

    // Segment pattern and anode for the currently scanned digit.
    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_digit = count_q[4*k +: 4];
                cur_dp    = DP[k];
            end
        end
        glyph = seg_decode(cur_digit);
`ifdef MDC_LEADING_ZERO_BLANK_EN
        // Blank a digit when it and everything above it are zero; digit 0 always shows.
        zero_above = 1'b1;
        blank      = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (count_q[4*k +: 4] == 4'd0);
            if (idx_q == IW'(k)) begin
                blank = zero_above;
            end
        end
        if (blank) begin
            glyph = SEG_BLANK;
        end
`endif
        seg_d   = {glyph[7:1], ~cur_dp};
        anode_d = ~(DIGITS'(1) << idx_q);
    end

    // Counter, scan index and registered display outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            seg_q   <= SEG_0;
            anode_q <= ~(DIGITS'(1));
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            anode_q <= anode_d;
        end
    end

    assign Count_out = count_q;
    assign Carry     = carry_q;
    assign SSeg      = seg_q;
    assign Anode     = anode_q;
    assign Tick      = tick_cnt;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench: hex and BCD instances share stimulus; an arithmetic model checks every cycle.
// Latency: model expects 1-Clk count/display latency.
// Backpressure: none.
module tb_multi_digit_counter;

    localparam int DIV    = 10;
    localparam int SDIV   = 4;
    localparam int DIGITS = 4;

    logic        Clk      = 1'b0;
    logic        Reset    = 1'b1;
    logic        Load     = 1'b0;
    logic        Count_en = 1'b0;
    logic        Up       = 1'b1;
    logic [3:0]  DP       = 4'b0000;
    logic [15:0] Count_in = 16'h0000;

    logic [15:0] cnt_h, cnt_b;
    logic        carry_h, carry_b;
    logic [7:0]  seg_h, seg_b;
    logic [3:0]  an_h, an_b;
    logic        tick_h, tick_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 Clk = ~Clk;

    multi_digit_counter #(.OLD_HZ(20), .NEW_HZ(2), .SCAN_HZ(5), .DIGITS(4), .BCD(0)) dut_hex (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Count_en(Count_en), .Up(Up), .DP(DP),
        .Count_in(Count_in), .Count_out(cnt_h), .Carry(carry_h), .SSeg(seg_h),
        .Anode(an_h), .Tick(tick_h)
    );

    multi_digit_counter #(.OLD_HZ(20), .NEW_HZ(2), .SCAN_HZ(5), .DIGITS(4), .BCD(1)) dut_bcd (
        .Clk(Clk), .Reset(Reset), .Load(Load), .Count_en(Count_en), .Up(Up), .DP(DP),
        .Count_in(Count_in), .Count_out(cnt_b), .Carry(carry_b), .SSeg(seg_b),
        .Anode(an_b), .Tick(tick_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Standard active-low glyphs A..G.
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int word, input int idx, input logic [3:0] dp);
        int d;
        logic [6:0] g;
        d = (word >> (4 * idx)) & 15;
        g = glyph(d);
`ifdef MDC_LEADING_ZERO_BLANK_EN
        if (idx != 0 && (word >> (4 * idx)) == 0) g = 7'b1111111;
`endif
        return {g, ~dp[idx]};
    endfunction

    function automatic int bcd_word(input int v);
        int w;
        int p;
        w = 0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            w = w | (((v / p) % 10) << (4 * k));
            p = p * 10;
        end
        return w;
    endfunction

    function automatic int bcd_load(input logic [15:0] in);
        int v;
        int p;
        int n;
        v = 0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            n = int'(in[4*k +: 4]);
            if (n > 9) n = 0;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    // Model state: cycles since reset release and numeric counter values.
    int         m_cyc;
    int         m_h, m_b;
    logic       m_ch, m_cb;
    logic [3:0] m_an;
    logic [7:0] m_seg_h, m_seg_b;

    always @(negedge Clk) begin
        logic tick;
        int   idx;
        if (Reset) begin
            m_cyc = 0; m_h = 0; m_b = 0; m_ch = 1'b0; m_cb = 1'b0;
            m_an = 4'b1110; m_seg_h = 8'b0000_0011; m_seg_b = 8'b0000_0011;
        end
        tick = !Reset && ((m_cyc % DIV) == DIV - 1);
        chk("m_cnt_h",   32'(cnt_h),   32'(m_h));
        chk("m_cnt_b",   32'(cnt_b),   32'(bcd_word(m_b)));
        chk("m_carry_h", 32'(carry_h), 32'(m_ch));
        chk("m_carry_b", 32'(carry_b), 32'(m_cb));
        chk("m_tick_h",  32'(tick_h),  32'(tick));
        chk("m_tick_b",  32'(tick_b),  32'(tick));
        chk("m_an_h",    32'(an_h),    32'(m_an));
        chk("m_an_b",    32'(an_b),    32'(m_an));
        chk("m_seg_h",   32'(seg_h),   32'(m_seg_h));
        chk("m_seg_b",   32'(seg_b),   32'(m_seg_b));
        if (!Reset) begin
            idx     = (m_cyc / SDIV) % DIGITS;
            m_an    = ~(4'b0001 << idx);
            m_seg_h = exp_seg(m_h, idx, DP);
            m_seg_b = exp_seg(bcd_word(m_b), idx, DP);
            m_ch = 1'b0;
            m_cb = 1'b0;
            if (Load) begin
                m_h = int'(Count_in);
                m_b = bcd_load(Count_in);
            end else if (Count_en && tick) begin
                if (Up) begin
                    m_ch = (m_h == 65535);
                    m_cb = (m_b == 9999);
                    m_h  = (m_h + 1) % 65536;
                    m_b  = (m_b + 1) % 10000;
                end else begin
                    m_ch = (m_h == 0);
                    m_cb = (m_b == 0);
                    m_h  = (m_h + 65535) % 65536;
                    m_b  = (m_b + 9999) % 10000;
                end
            end
            m_cyc++;
        end
    end

    // Advance to 1 time unit after the rising edge that starts cycle 'target'.
    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc   = 0;

        // Run from 0x12A, then reset asynchronously mid-cycle.
        Load = 1'b1; Count_in = 16'h012A;
        goto(1);
        Load = 1'b0; Count_en = 1'b1; Up = 1'b1;
        goto(15);
        chk("run_12b_h", 32'(cnt_h), 32'h012B);
        chk("run_12b_b", 32'(cnt_b), 32'h0121);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_cnt",   32'(cnt_h),   32'h0000);
        chk("arst_anode", 32'(an_h),    32'b1110);
        chk("arst_sseg",  32'(seg_h),   32'b0000_0011);
        chk("arst_carry", 32'(carry_h), 32'h0);
        chk("arst_tick",  32'(tick_h),  32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc   = 0;
        goto(8);
        chk("tick_c8",  32'(tick_h), 32'h0);
        goto(9);
        chk("tick_c9",  32'(tick_h), 32'h1);
        goto(10);
        chk("first_inc", 32'(cnt_h), 32'h0001);

        // BCD up wrap from 9999.
        Load = 1'b1; Count_in = 16'h9999;
        goto(11);
        Load = 1'b0;
        goto(20);
        chk("bcd_wrap_cnt",   32'(cnt_b),   32'h0000);
        chk("bcd_wrap_carry", 32'(carry_b), 32'h1);
        chk("hex_999a",       32'(cnt_h),   32'h999A);
        chk("hex_no_carry",   32'(carry_h), 32'h0);
        goto(21);
        chk("bcd_carry_pulse", 32'(carry_b), 32'h0);
        Load = 1'b1; Count_in = 16'h12F4;
        goto(22);
        Load = 1'b0;
        chk("bcd_load_12f4", 32'(cnt_b), 32'h1204);
        chk("hex_load_12f4", 32'(cnt_h), 32'h12F4);

        // Down wrap from zero.
        Load = 1'b1; Count_in = 16'h0000; Up = 1'b0;
        goto(23);
        Load = 1'b0;
        goto(30);
        chk("down_wrap_h",  32'(cnt_h),   32'hFFFF);
        chk("down_carry_h", 32'(carry_h), 32'h1);
        chk("down_wrap_b",  32'(cnt_b),   32'h9999);
        chk("down_carry_b", 32'(carry_b), 32'h1);
        goto(40);
        chk("down_fffe",    32'(cnt_h),   32'hFFFE);
        chk("down_fffe_c",  32'(carry_h), 32'h0);

        // Load on a tick cycle wins.
        goto(49);
        chk("tick_c49", 32'(tick_h), 32'h1);
        Load = 1'b1; Count_in = 16'h0005; Up = 1'b1;
        goto(50);
        Load = 1'b0;
        chk("load_win_h",  32'(cnt_h),   32'h0005);
        chk("load_win_c",  32'(carry_h), 32'h0);
        chk("load_win_b",  32'(cnt_b),   32'h0005);
        chk("load_win_cb", 32'(carry_b), 32'h0);

        // Scan with distinct digits and DP on digit 2.
        Count_en = 1'b0; Load = 1'b1; Count_in = 16'h4321; DP = 4'b0100;
        goto(51);
        Load = 1'b0;
        goto(54);
        chk("scan_d1_an",  32'(an_h),  32'b1101);
        chk("scan_d1_seg", 32'(seg_h), 32'b0010_0101);
        goto(58);
        chk("scan_d2_an",  32'(an_h),  32'b1011);
        chk("scan_d2_seg", 32'(seg_h), 32'b0000_1100);
        goto(62);
        chk("scan_d3_an",  32'(an_h),  32'b0111);
        chk("scan_d3_seg", 32'(seg_h), 32'b1001_1001);

        // Leading-zero behaviour on 0x0030.
        Load = 1'b1; Count_in = 16'h0030;
        goto(63);
        Load = 1'b0;
        goto(66);
        chk("lz_d0", 32'(seg_h), 32'b0000_0011);
        goto(70);
        chk("lz_d1", 32'(seg_h), 32'b0000_1101);
        goto(74);
`ifdef MDC_LEADING_ZERO_BLANK_EN
        chk("lz_d2", 32'(seg_h), 32'b1111_1110);
`else
        chk("lz_d2", 32'(seg_h), 32'b0000_0010);
`endif
        goto(78);
        chk("lz_d3_an", 32'(an_h), 32'b0111);
`ifdef MDC_LEADING_ZERO_BLANK_EN
        chk("lz_d3", 32'(seg_h), 32'b1111_1111);
`else
        chk("lz_d3", 32'(seg_h), 32'b0000_0011);
`endif
        goto(82);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
